// File: rtl/minterm_fn_unit.sv
// minterm_fn_unit: decodes an IN_W-bit input to a one-hot minterm vector and
// ORs the minterms selected by each output's mask, with a 2-stage pipeline.
// Ports:
//   clk, reset (async, active-high)
//   in_valid, inp                 -> evaluation input
//   out_valid, fn_out, onehot     <- evaluation result, latency 2
//   cfg_start, cfg_sel            -> begin loading the mask of output cfg_sel
//   cfg_bit_valid, cfg_bit        -> serial mask bits, minterm 0 first
//   cfg_busy, cfg_done, cfg_err   <- load status
module minterm_fn_unit #(
    parameter int IN_W = 4,
    parameter int NOUT = 3,
    parameter logic [NOUT*(2**IN_W)-1:0] DEF_MASK =
        {16'hC08B, 16'h440C, 16'h4CC8}
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic [IN_W-1:0]                      inp,
    output logic                                 out_valid,
    output logic [NOUT-1:0]                      fn_out,
    output logic [(2**IN_W)-1:0]                 onehot,
    input  logic                                 cfg_start,
    input  logic [((NOUT>1)?$clog2(NOUT):1)-1:0] cfg_sel,
    input  logic                                 cfg_bit_valid,
    input  logic                                 cfg_bit,
    output logic                                 cfg_busy,
    output logic                                 cfg_done,
    output logic                                 cfg_err
);

    localparam int NM = 2**IN_W;
    localparam int SW = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int CW = $clog2(NM) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } cfg_state_e;

    cfg_state_e      state_q;
    logic [SW-1:0]   sel_q;
    logic [CW-1:0]   cnt_q;
    logic [NM-1:0]   sr_q;
    logic [NM-1:0]   mask_q [NOUT];
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    logic            s1_v_q;
    logic [NM-1:0]   s1_oh_q;
    logic [NM-1:0]   s1_oh_d;
    logic            ov_q;
    logic [NOUT-1:0] fn_q;
    logic [NOUT-1:0] fn_d;
    logic [NM-1:0]   oh_q;

    // One-hot decode of the input.
    always_comb begin
        s1_oh_d = '0;
        s1_oh_d[inp] = 1'b1;
    end

    // Stage 2 reads the registered masks, so a commit only affects results
    // computed after the commit edge.
    always_comb begin
        fn_d = '0;
        for (int k = 0; k < NOUT; k++) begin
            fn_d[k] = |(s1_oh_q & mask_q[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v_q  <= 1'b0;
            s1_oh_q <= '0;
            ov_q    <= 1'b0;
            fn_q    <= '0;
            oh_q    <= '0;
        end else begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_oh_q <= s1_oh_d;
            end
            ov_q <= s1_v_q;
            if (s1_v_q) begin
                oh_q <= s1_oh_q;
                fn_q <= fn_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            sr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < NOUT; k++) begin
                mask_q[k] <= DEF_MASK[k*NM +: NM];
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        if (32'(cfg_sel) < NOUT) begin
                            sel_q   <= cfg_sel;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= SHIFT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (cfg_bit_valid) begin
                        sr_q[cnt_q[CW-2:0]] <= cfg_bit;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(NM - 1)) begin
                            state_q <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    mask_q[sel_q] <= sr_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = ov_q;
    assign fn_out    = fn_q;
    assign onehot    = oh_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_minterm_fn_unit.sv
// tb_minterm_fn_unit: directed checks of evaluation, mask loading,
// rejected selects, commit ordering and reset during a load.
module tb_minterm_fn_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [3:0]  inp;
    logic        out_valid;
    logic [2:0]  fn_out;
    logic [15:0] onehot;
    logic        cfg_start;
    logic [1:0]  cfg_sel;
    logic        cfg_bit_valid;
    logic        cfg_bit;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;

    int checks = 0;
    int fails  = 0;

    logic [15:0] bm [3];

    minterm_fn_unit dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .inp           (inp),
        .out_valid     (out_valid),
        .fn_out        (fn_out),
        .onehot        (onehot),
        .cfg_start     (cfg_start),
        .cfg_sel       (cfg_sel),
        .cfg_bit_valid (cfg_bit_valid),
        .cfg_bit       (cfg_bit),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] fexp(input int i);
        return {bm[2][i], bm[1][i], bm[0][i]};
    endfunction

    task automatic set_defaults();
        bm[0] = 16'h4CC8;
        bm[1] = 16'h440C;
        bm[2] = 16'hC08B;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid      = 1'b0;
            cfg_start     = 1'b0;
            cfg_bit_valid = 1'b0;
        end
    endtask

    // inp = 0..15 back to back; each result appears after the 2nd edge.
    task automatic sweep(input string tag);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            in_valid = (c < 16);
            inp      = 4'(c);
            @(posedge clk);
            #1;
            if (c == 0 || c == 17) begin
                check({tag, "_ov_lo"}, 32'(out_valid), 32'd0);
            end else begin
                check({tag, "_ov"}, 32'(out_valid), 32'd1);
                check({tag, "_fn"}, 32'(fn_out), 32'(fexp(c - 1)));
                check({tag, "_oh"}, 32'(onehot), 32'd1 << (c - 1));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic cfg_load(input logic [1:0] sel, input logic [15:0] data,
                            input int stall_at, input bit bnd);
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_sel   = sel;
        @(posedge clk);
        #1;
        check("ld_busy_start", 32'(cfg_busy), 32'd1);
        check("ld_err_start", 32'(cfg_err), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    cfg_bit_valid = 1'b0;
                    cfg_bit       = ~data[i];
                    cfg_start     = (s == 2);
                    cfg_sel       = 2'd0;
                    @(posedge clk);
                    #1;
                    check("stall_err", 32'(cfg_err), 32'd0);
                    check("stall_busy", 32'(cfg_busy), 32'd1);
                end
            end
            @(negedge clk);
            cfg_start     = 1'b0;
            cfg_bit_valid = 1'b1;
            cfg_bit       = data[i];
            @(posedge clk);
            #1;
            if (i == 15) begin
                check("ld_busy_last", 32'(cfg_busy), 32'd1);
                check("ld_done_early", 32'(cfg_done), 32'd0);
            end
            if (bnd) begin
                check("bnd_ov_shift", 32'(out_valid), 32'd1);
                check("bnd_fn0_shift", 32'(fn_out[0]), 32'd0);
            end
        end
        // Commit cycle: a start here must be ignored.
        @(negedge clk);
        cfg_bit_valid = 1'b0;
        cfg_start     = (stall_at >= 0);
        cfg_sel       = 2'd0;
        @(posedge clk);
        #1;
        check("ld_done", 32'(cfg_done), 32'd1);
        check("ld_busy_clr", 32'(cfg_busy), 32'd0);
        check("ld_err_commit", 32'(cfg_err), 32'd0);
        if (bnd) begin
            check("bnd_ov_commit", 32'(out_valid), 32'd1);
            check("bnd_fn0_commit", 32'(fn_out[0]), 32'd0);
        end
        @(negedge clk);
        cfg_start = 1'b0;
        @(posedge clk);
        #1;
        check("ld_done_once", 32'(cfg_done), 32'd0);
        check("ld_busy_after", 32'(cfg_busy), 32'd0);
        if (bnd) begin
            check("bnd_ov_after", 32'(out_valid), 32'd1);
            check("bnd_fn0_after", 32'(fn_out[0]), 32'd1);
        end
        bm[sel] = data;
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        inp           = '0;
        cfg_start     = 1'b0;
        cfg_sel       = '0;
        cfg_bit_valid = 1'b0;
        cfg_bit       = 1'b0;
        set_defaults();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_fn", 32'(fn_out), 32'd0);
        check("rst_oh", 32'(onehot), 32'd0);
        check("rst_busy", 32'(cfg_busy), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        reset = 1'b0;
        idle(2);

        sweep("def");

        // Bad select
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_sel   = 2'd3;
        @(posedge clk);
        #1;
        check("bad_err", 32'(cfg_err), 32'd1);
        check("bad_busy", 32'(cfg_busy), 32'd0);
        @(negedge clk);
        cfg_start = 1'b0;
        @(posedge clk);
        #1;
        check("bad_err_pulse", 32'(cfg_err), 32'd0);
        check("bad_busy2", 32'(cfg_busy), 32'd0);
        idle(2);
        sweep("bad");

        // Reprogram mask 1
        cfg_load(2'd1, 16'h8001, -1, 1'b0);
        idle(2);
        sweep("rp1");

        // Stall with ignored starts, mask 2
        cfg_load(2'd2, 16'hA5C3, 7, 1'b0);
        idle(2);
        sweep("stall");

        // Commit boundary, mask 0, inp=5 continuously
        @(negedge clk);
        in_valid = 1'b1;
        inp      = 4'd5;
        @(negedge clk);
        @(negedge clk);
        cfg_load(2'd0, 16'h0020, -1, 1'b1);
        idle(2);
        sweep("bnd");

        // Reset in the middle of a load of mask 1
        @(negedge clk);
        in_valid  = 1'b1;
        inp       = 4'd3;
        cfg_start = 1'b1;
        cfg_sel   = 2'd1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = 1'(i);
            @(negedge clk);
        end
        cfg_bit_valid = 1'b0;
        check("mid_busy_pre", 32'(cfg_busy), 32'd1);
        check("mid_ov_pre", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_busy", 32'(cfg_busy), 32'd0);
        check("mid_ov", 32'(out_valid), 32'd0);
        check("mid_fn", 32'(fn_out), 32'd0);
        check("mid_oh", 32'(onehot), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        set_defaults();
        idle(2);
        sweep("mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/minterm_fn_unit.md
Name: minterm_fn_unit

Overview:
- Parametrised, pipelined successor to the team's decoder-plus-OR function generators.
- Decodes an IN_W-bit input to a one-hot minterm vector, then produces NOUT outputs, each the OR of the minterms selected by that output's mask.
- Masks are runtime-programmable through a serial configuration port and reset to built-in defaults.
- Sits between lab input switches/stimulus and downstream display or checking logic.

Parameters:
- IN_W, 4, decoder input width; minterm count NM = 2**IN_W.
- NOUT, 3, number of function outputs.
- DEF_MASK, {16'hC08B, 16'h440C, 16'h4CC8}, reset masks, NOUT*NM bits. Slice k (bits k*NM +: NM) is output k's mask; bit m set means minterm m is included.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  inp is valid this cycle.
- inp  input  IN_W  function input.
- out_valid  output  1  fn_out and onehot are valid.
- fn_out  output  NOUT  function results; bit k is output k.
- onehot  output  NM  registered decode of the input aligned with fn_out.
- cfg_start  input  1  begin loading a mask for output cfg_sel.
- cfg_sel  input  max(1,$clog2(NOUT))  target output index, sampled at cfg_start.
- cfg_bit_valid  input  1  cfg_bit is valid this cycle.
- cfg_bit  input  1  serial mask bit, minterm 0 first.
- cfg_busy  output  1  high while a load is in progress.
- cfg_done  output  1  one-cycle pulse when the new mask is committed.
- cfg_err  output  1  one-cycle pulse when cfg_start is rejected.

Behaviour:
- Reset is asynchronous:
  - masks load DEF_MASK;
  - out_valid, fn_out, onehot, cfg_busy, cfg_done and cfg_err go to 0;
  - stage-1 valid and data are cleared;
  - the FSM enters IDLE and the bit counter and shift register clear.
- Reset during a load abandons the load; the target mask returns to its default.
- Evaluation pipeline: fixed latency 2, accepts one input per cycle, no backpressure.
  - Stage 1, cycle t: if in_valid, the one-hot decode of inp is registered (exactly one bit set) and stage-1 valid is set. Otherwise stage-1 valid goes to 0 and the stage-1 data holds its value.
  - Stage 2, cycle t+1: out_valid <= stage-1 valid. When stage-1 valid is set:
    - onehot <= stage-1 data;
    - fn_out[k] <= |(stage-1 data & mask_k).
  - When stage-1 valid is 0, fn_out and onehot hold their last values.
- Configuration FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: on cfg_start with cfg_sel < NOUT, latch cfg_sel, clear the counter, set cfg_busy and go to SHIFT. On cfg_start with cfg_sel >= NOUT, pulse cfg_err and stay in IDLE.
  - SHIFT: each cycle with cfg_bit_valid, store cfg_bit at shift position cnt and increment cnt. cfg_bit_valid low stalls the load indefinitely. cfg_start is ignored in SHIFT, with no cfg_err. When bit NM-1 is accepted, go to COMMIT.
  - COMMIT: replace the selected mask atomically with the shift register, pulse cfg_done, clear cfg_busy and return to IDLE. cfg_start in the COMMIT cycle is ignored.
  - cfg_bit_valid in IDLE or COMMIT is ignored.
- Mask/evaluation ordering:
  - Stage 2 always reads the registered mask. A computation in the COMMIT cycle uses the old mask; the next cycle uses the new one.
  - Evaluation is never stalled by configuration. Masks not being loaded are untouched.
- Counter width is $clog2(NM)+1 so that it does not wrap before NM is reached. Minterm indexing is unsigned. NOUT=1 is legal: cfg_sel is 1 bit and value 1 is rejected.

Test Plan:
- Reset defaults:
  - Stimulus: assert reset, release, then drive in_valid with inp = 0..15 on consecutive cycles.
  - Required: out_valid rises 2 cycles after the first input. fn_out follows the default masks 4CC8/440C/C08B; e.g. inp=3 -> fn_out=3'b111, inp=10 -> 3'b011, inp=0 -> 3'b100. onehot = 1<<inp.
- Reprogramming:
  - Stimulus: cfg_start with cfg_sel=1, then 16 bits of 0x8001, LSB first.
  - Required: cfg_busy high for the load; cfg_done pulses once. Afterwards inp=0 and inp=15 give fn_out[1]=1 and inp=3 gives fn_out[1]=0; fn_out[0] and fn_out[2] are unchanged.
- Stall and ignored start:
  - Stimulus: during a load, drop cfg_bit_valid for 5 cycles and pulse cfg_start.
  - Required: no cfg_err pulse; the committed mask equals the bits sent, and bits are neither lost nor duplicated.
- Bad select:
  - Stimulus: cfg_start with cfg_sel=3 while NOUT=3.
  - Required: cfg_err pulses for 1 cycle; cfg_busy stays 0 and all masks are unchanged.
- Commit boundary:
  - Stimulus: in_valid continuously with inp=5 while mask 0 is loaded with 0x0020.
  - Required: fn_out[0] is 0 through the COMMIT cycle, then 1 from the first result computed afterwards; no gap in out_valid.
- Reset mid-load:
  - Stimulus: assert reset after 8 of 16 bits.
  - Required: immediately cfg_busy=0 and out_valid=0; after release, mask 1 reads the default 440C.
